// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    typedef logic [3:0] digit_t;

    // ceil(w * log10(2)) using a fixed-point approximation of log10(2)
    function automatic int digits_for(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_dbl.sv
// One registered decimal digit: d' = 2*d + cin with decimal correction.
module bcd_digit_dbl
    import bcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    input  logic   cin,
    output digit_t digit,
    output logic   cout
);

    logic [4:0] t;

    // {d, cin} is exactly 2*d + cin
    assign t    = {digit, cin};
    assign cout = (t > 5'd9);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit <= '0;
        end else if (en) begin
            digit <= cout ? digit_t'(t - 5'd10) : t[3:0];
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Handshaked MSB-first binary-to-BCD converter, one bit per clock,
// with optional two's-complement input and sticky decimal overflow.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                sign_out,
    output logic                overflow
);

    localparam int CNT_W = $clog2(BIN_W);

    if (BIN_W < 2) begin : g_bad_bin_w
        $error("BIN_W must be >= 2");
    end
    if (DIGITS < 1) begin : g_bad_digits
        $error("DIGITS must be >= 1");
    end

    state_t             state;
    state_t             state_nx;
    logic [BIN_W-1:0]   shreg;
    logic [BIN_W-1:0]   mag;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               shift;
    logic [DIGITS:0]    carry;

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid;
    assign shift    = (state == CONV);

    // most negative value negates to itself, which is the correct magnitude
    assign mag = (SIGNED && bin_in[BIN_W-1]) ? -bin_in : bin_in;

    assign carry[0] = shreg[BIN_W-1];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        bcd_digit_dbl u_dig (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept),
            .en    (shift),
            .cin   (carry[gi]),
            .digit (bcd_out[4*gi +: 4]),
            .cout  (carry[gi+1])
        );
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = CONV;
            CONV:    if (cnt == '0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            sign_out  <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (state_nx == DONE);
            if (accept) begin
                shreg    <= mag;
                cnt      <= CNT_W'(BIN_W - 1);
                sign_out <= SIGNED && bin_in[BIN_W-1];
                overflow <= 1'b0;
            end else if (shift) begin
                shreg    <= shreg << 1;
                cnt      <= cnt - 1'b1;
                overflow <= overflow | carry[DIGITS];
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized bench for bin_to_bcd_seq against a decimal-arithmetic model,
// covering unsigned, narrow-overflow and signed instances.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        iv   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        sg   [3];
    logic        of   [3];
    logic [19:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .bin_in(din), .out_valid(ov[0]), .out_ready(ordy[0]),
        .bcd_out(bcd_a), .sign_out(sg[0]), .overflow(of[0])
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .bin_in(din[7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .bcd_out(bcd_b), .sign_out(sg[1]), .overflow(of[1])
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .bin_in(din), .out_valid(ov[2]), .out_ready(ordy[2]),
        .bcd_out(bcd_c), .sign_out(sg[2]), .overflow(of[2])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int k);
        return (k == 1) ? 8 : 16;
    endfunction

    function automatic logic [31:0] bcd_of(input int k);
        case (k)
            0:       return {12'b0, bcd_a};
            1:       return {24'b0, bcd_b};
            default: return {12'b0, bcd_c};
        endcase
    endfunction

    // decimal reference: magnitude, sign, value mod 10^D, overflow
    task automatic model(input int k, input logic [15:0] v,
                         output logic [31:0] bcd, output logic sgn,
                         output logic ovf);
        int     w;
        int     d;
        longint x;
        longint mag;
        longint p;
        longint r;
        w   = width_of(k);
        d   = (k == 1) ? 2 : 5;
        x   = longint'(v) & ((64'd1 << w) - 1);
        sgn = (k == 2) && x[w-1];
        mag = sgn ? (64'd1 << w) - x : x;
        p   = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        ovf = (mag >= p);
        r   = mag % p;
        bcd = '0;
        for (int i = 0; i < d; i++) begin
            bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] v);
        int n = 0;
        din   = v;
        iv[k] = 1'b1;
        while (!ir[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        tick();
        iv[k] = 1'b0;
        check("busy_after_accept", 32'(ir[k]), 0);
    endtask

    task automatic await_chk(input int k, input logic [15:0] v);
        int          c = 0;
        logic [31:0] eb;
        logic        es;
        logic        eo;
        while (!ov[k] && c < 200) begin
            tick();
            c++;
        end
        check("latency", c, width_of(k));
        model(k, v, eb, es, eo);
        check("bcd", bcd_of(k), eb);
        check("sign", 32'(sg[k]), 32'(es));
        check("ovf", 32'(of[k]), 32'(eo));
        check("ready_in_done", 32'(ir[k]), 0);
    endtask

    task automatic release_out(input int k);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        check("valid_after_release", 32'(ov[k]), 0);
        check("ready_after_release", 32'(ir[k]), 1);
    endtask

    task automatic convert(input int k, input logic [15:0] v);
        send(k, v);
        await_chk(k, v);
        release_out(k);
    endtask

    initial begin
        logic [31:0] held;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(ir[i]), 1);
            check("rst_valid", 32'(ov[i]), 0);
            check("rst_bcd", bcd_of(i), 0);
            check("rst_sign", 32'(sg[i]), 0);
            check("rst_ovf", 32'(of[i]), 0);
        end

        convert(0, 16'h04D2);
        convert(0, 16'h0000);
        convert(0, 16'hFFFF);
        convert(1, 16'h00FF);
        convert(1, 16'h0063);
        convert(1, 16'h0064);
        convert(2, 16'h8000);
        convert(2, 16'hFFFF);
        convert(2, 16'h0000);
        convert(2, 16'h7FFF);

        // back-pressure: result held, second word waits for release
        send(0, 16'd4321);
        await_chk(0, 16'd4321);
        held  = bcd_of(0);
        din   = 16'd777;
        iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(ov[0]), 1);
            check("bp_ready", 32'(ir[0]), 0);
            check("bp_bcd", bcd_of(0), held);
        end
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("bp_rel_valid", 32'(ov[0]), 0);
        check("bp_rel_ready", 32'(ir[0]), 1);
        tick();
        iv[0] = 1'b0;
        check("bp_second_taken", 32'(ir[0]), 0);
        await_chk(0, 16'd777);
        release_out(0);

        // reset mid-conversion discards the word
        send(0, 16'hBEEF);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(ir[0]), 1);
        check("midrst_valid", 32'(ov[0]), 0);
        check("midrst_bcd", bcd_of(0), 0);
        convert(0, 16'd9999);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 3; k++) begin
                convert(k, 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised sequential binary-to-BCD converter. It accepts one BIN_W-bit binary word over a valid/ready handshake and converts it MSB-first, one bit per clock, through a chain of DIGITS decimal doubling cells. It presents the packed BCD result, a sign flag and an overflow flag over a second valid/ready handshake. It is the multi-digit, handshaked, signed-capable successor to the single decimal digit accumulator cell.

## Interface
Parameters:
- BIN_W, default 16: binary input width, ≥ 2.
- DIGITS, default 5: number of BCD digits. Values below bcd_pkg::digits_for(BIN_W) are legal; out-of-range results are flagged through overflow.
- SIGNED, default 0: 1 means bin_in is two's complement and the magnitude is converted.

Ports. One clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- bin_in  input  BIN_W  binary operand.
- out_valid  output  1  result registers are valid.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- sign_out  output  1  1 means the operand was negative (SIGNED=1 only, else 0).
- overflow  output  1  a decimal carry left the top digit during the conversion.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load the shift register with the magnitude of bin_in (two's-complement negate if SIGNED and MSB=1), latch sign_out, clear all digits and overflow, set bit counter to BIN_W-1, go to CONV.
- CONV, each cycle:
  - Shift register shifts left; its MSB is carry-in to digit 0.
  - Every digit d computes t = 2*d + cin. If t > 9, then d' = t - 10 and cout = 1; else d' = t and cout = 0.
  - cout of digit i is cin of digit i+1; cout of the top digit ORs into sticky overflow.
  - Counter decrements. When the counter reaches 0, the current shift is the last one and the next state is DONE.
- DONE:
  - out_valid=1; bcd_out, sign_out and overflow are held stable.
  - On out_ready, go to IDLE.
- Arithmetic: digits are always 0..9; with sufficient DIGITS the result equals the decimal value exactly. With insufficient DIGITS, bcd_out = value mod 10^DIGITS and overflow=1.
- SIGNED: the most negative input has magnitude 2^(BIN_W-1). This fits the BIN_W-bit shift register unsigned and needs no special case.
- Zero: sign_out is never 1 for a zero magnitude.
- Reset (any state, including mid-CONV):
  - State goes to IDLE.
  - Shift register, counter, digits, bcd_out, sign_out and overflow go to 0; out_valid goes to 0.
  - in_ready=1 from the first cycle after the reset edge.
  - The in-flight word is discarded, with no partial output.
- in_valid in CONV or DONE is ignored; the word is not consumed because in_ready=0.

## Timing
- Handshake: a transfer occurs on a clock edge where valid and ready are both 1. The producer must hold bin_in stable while in_valid=1 and in_ready=0.
- Latency: when acceptance happens on edge E, out_valid is 1 after edge E+BIN_W, i.e. exactly BIN_W cycles in CONV.
- Throughput: one word per BIN_W+2 cycles when out_ready is held at 1 (accept edge, BIN_W conversion edges, release edge).
- bcd_out during CONV shows partial digits and is valid only while out_valid=1.
- All outputs are registered except in_ready, which is decoded from state only and has no combinational path from any input.

## Structure
- bcd_pkg holds:
  - state enum (IDLE, CONV, DONE);
  - BCD digit typedef (logic [3:0]);
  - constant function digits_for(w) = ceil(w*log10(2)), used for parameter checks and bench sizing.
- Sub-module bcd_digit_dbl: one registered digit, computing d' = 2*d + cin with decimal correction.
  - Ports: clk, rst, clr, en, cin, digit, cout.
  - Instantiated DIGITS times in a generate loop.
- Elaboration assertions: BIN_W ≥ 2, DIGITS ≥ 1.

## Test plan
- BIN_W=16, DIGITS=5, SIGNED=0, bin_in=16'h04D2 → after 16 cycles bcd_out=20'h01234, overflow=0, sign_out=0.
- Boundary values: bin_in=0 → 20'h00000; bin_in=16'hFFFF → 20'h65535, overflow=0.
- BIN_W=8, DIGITS=2, bin_in=8'hFF → bcd_out=8'h55, overflow=1.
- SIGNED=1, BIN_W=16, bin_in=16'h8000 → sign_out=1, bcd_out=20'h32768; bin_in=16'hFFFF → sign_out=1, bcd_out=20'h00001.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0; a second in_valid is not taken until one cycle after out_ready=1.
- Reset: assert rst 7 cycles into CONV → next cycle in_ready=1, out_valid=0, bcd_out=0. Then a fresh 16'd9999 converts to 20'h09999.
